// File: rtl/bus_dma_copy_if.sv
// rtl/bus_dma_copy_if.sv - command, status and memory-bus signals of the byte-copy DMA
interface bus_dma_copy_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              start_i;
    logic              abort_i;
    logic [ADDR_W-1:0] src_i;
    logic [ADDR_W-1:0] dst_i;
    logic [ADDR_W-1:0] len_i;
    logic              busy_o;
    logic              done_o;
    logic [ADDR_W-1:0] count_o;
    logic [ADDR_W-1:0] dma_addr_o;
    logic              dma_oe_o;
    logic              dma_we_o;
    logic [DATA_W-1:0] dma_data_o;
    logic [DATA_W-1:0] dma_data_i;

    modport slave (
        input  start_i, abort_i, src_i, dst_i, len_i, dma_data_i,
        output busy_o, done_o, count_o, dma_addr_o, dma_oe_o, dma_we_o, dma_data_o
    );

    modport master (
        output start_i, abort_i, src_i, dst_i, len_i, dma_data_i,
        input  busy_o, done_o, count_o, dma_addr_o, dma_oe_o, dma_we_o, dma_data_o
    );
endinterface

// File: rtl/bus_dma_copy.sv
// rtl/bus_dma_copy.sv - byte-at-a-time memory copy engine with six-phase strobed bus cycles
module bus_dma_copy #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic            cpu_clk,
    input  logic            cpu_reset,
    bus_dma_copy_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE, RD_SETUP, RD_STROBE, RD_HOLD, WR_SETUP, WR_STROBE, WR_HOLD, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              oe_q, oe_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;
        byte_d  = byte_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.abort_i) begin
                    src_d   = bus.src_i;
                    dst_d   = bus.dst_i;
                    count_d = bus.len_i;
                    state_d = (bus.len_i == '0) ? DONE : RD_SETUP;
                end
            end
            RD_SETUP:  state_d = RD_STROBE;
            RD_STROBE: begin
                byte_d  = bus.dma_data_i;
                state_d = RD_HOLD;
            end
            RD_HOLD:   state_d = WR_SETUP;
            WR_SETUP:  state_d = WR_STROBE;
            WR_STROBE: state_d = WR_HOLD;
            WR_HOLD: begin
                src_d   = src_q + ONE;
                dst_d   = dst_q + ONE;
                count_d = count_q - ONE;
                state_d = (count_q == ONE) ? DONE : RD_SETUP;
            end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        // Abort freezes progress: count keeps the bytes not yet completed.
        if (bus.abort_i && state_q != IDLE && state_q != DONE) begin
            state_d = IDLE;
            src_d   = src_q;
            dst_d   = dst_q;
            count_d = count_q;
            byte_d  = byte_q;
        end

        // Bus outputs are registered from the state being entered.
        addr_d = addr_q;
        data_d = data_q;
        case (state_d)
            RD_SETUP, RD_STROBE, RD_HOLD: addr_d = src_d;
            WR_SETUP, WR_STROBE, WR_HOLD: addr_d = dst_d;
            default:                      addr_d = addr_q;
        endcase
        if (state_d == WR_SETUP) begin
            data_d = byte_d;
        end
        oe_d   = (state_d == RD_STROBE);
        we_d   = (state_d == WR_STROBE);
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            byte_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.count_o    = count_q;
    assign bus.dma_addr_o = addr_q;
    assign bus.dma_oe_o   = oe_q;
    assign bus.dma_we_o   = we_q;
    assign bus.dma_data_o = data_q;
endmodule

// File: tb/tb_bus_dma_copy.sv
// tb/tb_bus_dma_copy.sv - scoreboard bench for bus_dma_copy with a memory model and transfer-level reference
module tb_bus_dma_copy;
    logic cpu_clk = 1'b0;
    logic cpu_reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [15:0] cnt;
    } ev_t;

    ev_t         evq[$];
    int          donq[$];
    logic [7:0]  mem  [0:65535];
    logic [7:0]  refm [0:65535];

    bus_dma_copy_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    bus_dma_copy #(.ADDR_W(16), .DATA_W(8)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_reset (cpu_reset),
        .bus       (bus)
    );

    always #5 cpu_clk = ~cpu_clk;
    always @(posedge cpu_clk) cyc <= cyc + 1;

    always @(posedge bus.dma_oe_o) bus.dma_data_i <= mem[bus.dma_addr_o];
    always @(posedge bus.dma_we_o) mem[bus.dma_addr_o] <= bus.dma_data_o;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transfer-level reference: byte i is read from src+i and written to dst+i.
    task automatic model_copy(input logic [15:0] s, input logic [15:0] d,
                              input logic [15:0] l, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            logic [15:0] ra, wa;
            logic [7:0]  v;
            ra = s + 16'(i);
            wa = d + 16'(i);
            v  = refm[ra];
            evq.push_back('{1'b0, ra, 8'h00, 16'h0000});
            evq.push_back('{1'b1, wa, v, l - 16'(i)});
            refm[wa] = v;
        end
    endtask

    always @(negedge cpu_clk) begin
        if (!cpu_reset) begin
            if (bus.dma_oe_o || bus.dma_we_o) begin
                chk("strobe_exclusive", {31'd0, bus.dma_oe_o && bus.dma_we_o}, 32'd0);
                if (evq.size() == 0) begin
                    chk("strobe_expected", evq.size(), 32'd1);
                end else begin
                    ev_t e;
                    e = evq.pop_front();
                    chk("ev_kind", {31'd0, bus.dma_we_o}, {31'd0, e.is_wr});
                    chk("ev_addr", bus.dma_addr_o, e.addr);
                    if (e.is_wr) begin
                        chk("ev_wdata", bus.dma_data_o, e.data);
                        chk("ev_count", bus.count_o, e.cnt);
                    end
                end
            end
            if (bus.done_o) begin
                if (donq.size() == 0) chk("done_expected", donq.size(), 32'd1);
                else                  chk("done_cycle", cyc, donq.pop_front());
            end
        end
    end

    task automatic issue(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                         input int nbytes, input bit want_done);
        @(negedge cpu_clk);
        model_copy(s, d, l, nbytes);
        if (want_done) donq.push_back(cyc + 1 + 6 * int'(l));
        bus.src_i   = s;
        bus.dst_i   = d;
        bus.len_i   = l;
        bus.start_i = 1'b1;
        @(posedge cpu_clk);
        #1 bus.start_i = 1'b0;
    endtask

    task automatic finish_xfer(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge cpu_clk);
            #1;
            ok = !bus.busy_o && !bus.done_o && evq.size() == 0 && donq.size() == 0;
        end
        chk("xfer_complete_in_budget", {31'd0, ok}, 32'd1);
        chk("drain_events", evq.size(), 32'd0);
        chk("drain_done", donq.size(), 32'd0);
        chk("idle_count", bus.count_o, 32'd0);
        evq.delete();
        donq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.src_i   = '0;
        bus.dst_i   = '0;
        bus.len_i   = '0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]  = 8'($urandom);
            refm[i] = mem[i];
        end

        // Reset state, during and after reset
        repeat (2) @(negedge cpu_clk);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_oe", bus.dma_oe_o, 0);
        chk("rst_we", bus.dma_we_o, 0);
        cpu_reset = 1'b0;
        @(negedge cpu_clk);
        chk("rel_busy", bus.busy_o, 0);
        chk("rel_done", bus.done_o, 0);
        chk("rel_count", bus.count_o, 0);
        chk("rel_addr", bus.dma_addr_o, 0);
        chk("rel_data", bus.dma_data_o, 0);
        chk("rel_strobes", {bus.dma_oe_o, bus.dma_we_o}, 0);

        // Three-byte copy
        mem[16'h1000] = 8'h3F; refm[16'h1000] = 8'h3F;
        mem[16'h1001] = 8'h10; refm[16'h1001] = 8'h10;
        mem[16'h1002] = 8'hC6; refm[16'h1002] = 8'hC6;
        issue(16'h1000, 16'h2000, 16'd3, 3, 1'b1);
        finish_xfer(40);
        chk("mem_2000", mem[16'h2000], 8'h3F);
        chk("mem_2001", mem[16'h2001], 8'h10);
        chk("mem_2002", mem[16'h2002], 8'hC6);

        // Zero length: done next cycle, no strobes
        issue(16'h4000, 16'h5000, 16'd0, 0, 1'b1);
        finish_xfer(10);

        // Address wrap with overlapping ranges
        issue(16'hFFFF, 16'hFFFE, 16'd2, 2, 1'b1);
        finish_xfer(30);

        // Start while busy ignored, abort during second write strobe
        begin
            int wseen;
            wseen = 0;
            issue(16'h3000, 16'h3100, 16'd4, 2, 1'b0);
            for (int i = 0; i < 40 && wseen < 2; i++) begin
                @(negedge cpu_clk);
                #1;
                if (i == 2) begin
                    bus.src_i = 16'h7777; bus.len_i = 16'd1; bus.start_i = 1'b1;
                end else begin
                    bus.start_i = 1'b0;
                end
                if (bus.dma_we_o) wseen++;
            end
            bus.start_i = 1'b0;
            chk("abort_reached_wr2", wseen, 2);
            bus.abort_i = 1'b1;
            @(posedge cpu_clk);
            #1 bus.abort_i = 1'b0;
            chk("abort_we", bus.dma_we_o, 0);
            chk("abort_oe", bus.dma_oe_o, 0);
            chk("abort_busy", bus.busy_o, 0);
            chk("abort_done", bus.done_o, 0);
            chk("abort_count", bus.count_o, 3);
            repeat (12) @(negedge cpu_clk);
            #1 chk("abort_stays_idle", bus.busy_o, 0);
            chk("abort_no_events", evq.size(), 0);
        end

        // Asynchronous reset in the middle of a read strobe
        begin
            bit seen;
            seen = 1'b0;
            evq.push_back('{1'b0, 16'h0800, 8'h00, 16'h0000});
            issue(16'h0800, 16'h0900, 16'd3, 0, 1'b0);
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge cpu_clk);
                #1 seen = bus.dma_oe_o;
            end
            chk("rst_mid_saw_oe", {31'd0, seen}, 1);
            #2 cpu_reset = 1'b1;
            #1;
            chk("rst_mid_oe_async", bus.dma_oe_o, 0);
            chk("rst_mid_busy_async", bus.busy_o, 0);
            chk("rst_mid_addr_async", bus.dma_addr_o, 0);
            repeat (2) @(negedge cpu_clk);
            cpu_reset = 1'b0;
            evq.delete();
            donq.delete();
            repeat (10) @(negedge cpu_clk);
            #1 chk("rst_mid_idle", {bus.busy_o, bus.dma_oe_o, bus.dma_we_o}, 0);
            chk("rst_mid_count", bus.count_o, 0);
            // refm tracks mem: the interrupted transfer never wrote
            for (int i = 0; i < 65536; i++) refm[i] = mem[i];
        end

        // Random transfers
        for (int k = 0; k < 8; k++) begin
            logic [15:0] s, d, l;
            s = 16'($urandom);
            d = 16'($urandom);
            l = 16'($urandom_range(1, 5));
            issue(s, d, l, int'(l), 1'b1);
            finish_xfer(6 * int'(l) + 10);
            for (int i = 0; i < int'(l); i++) begin
                logic [15:0] a;
                a = d + 16'(i);
                chk("rand_mem", mem[a], refm[a]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
